core_fetch_unit: RTL
====================

Name: core_fetch_unit

Overview:
Parametrised instruction fetch front-end for the LETC core. It sits between the MMU instruction port and core_decode.
- Generates sequential fetch addresses and issues at most one outstanding memory request.
- Buffers returned instructions, with their PC and fault status, in a DEPTH-entry queue.
- Supports redirect (branch/trap), which flushes the queue and discards in-flight data.

Parameters:
DEPTH, 4, instruction queue entries (>=2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response valid (one cycle, no backpressure)
imem_rsp_data  input  32  fetched instruction word
imem_rsp_fault  input  1  access/page fault on this fetch
instr_valid  output  1  queue head valid to decode
instr_ready  input  1  decode consumes head
instr  output  32  head instruction
instr_pc  output  32  head PC
instr_fault  output  1  head fetch faulted
redirect_valid  input  1  redirect fetch stream
redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0)

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, queue count=0.
  - imem_req_valid=0, instr_valid=0.
  - instr, instr_pc, instr_fault=0.
- Credit: a new request may start only when count_next + outstanding < DEPTH. Responses therefore never overflow the queue; no full-drop path exists.
- FSM states: IDLE, REQ, WAIT, KILL_REQ, KILL_WAIT, FAULT.
  - IDLE: credit available -> REQ (registered). First imem_req_valid appears 1 cycle after rst_n release.
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc. Both are held stable until imem_req_ready. On accept: fetch_pc<=fetch_pc+4, go to WAIT.
  - WAIT: on imem_rsp_valid, enqueue {data, pc, fault}.
    - fault=1 -> FAULT.
    - Otherwise -> REQ if credit (using post-enqueue/dequeue count), else IDLE.
  - FAULT: no requests issued. Leaves only on redirect.
  - KILL_REQ: keeps the stale request asserted with its old address until accepted, then -> KILL_WAIT.
  - KILL_WAIT: the next response is discarded. Then -> REQ if credit, else IDLE.
- Redirect (redirect_valid=1), which has top priority:
  - Queue flushed (count<=0 next cycle).
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - instr_valid is forced 0 combinationally that cycle, so no dequeue occurs.
  - Next state by current state:
    - IDLE, FAULT -> IDLE.
    - REQ, not accepted this cycle -> KILL_REQ.
    - REQ, accepted this cycle -> KILL_WAIT.
    - WAIT, no response this cycle -> KILL_WAIT.
    - WAIT, response this cycle -> response dropped, -> IDLE.
    - KILL_*: stay in the same state; only fetch_pc updates.
- Queue behaviour:
  - Response accepted in cycle N is visible on instr_valid in cycle N+1 (no bypass).
  - Simultaneous enqueue and dequeue keeps count constant.
  - Pointers wrap modulo DEPTH.
  - instr/instr_pc/instr_fault are valid only while instr_valid=1.
- Arithmetic: fetch_pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). Count width is $clog2(DEPTH+1).
- Reset mid-operation: asserting rst_n low returns all state to reset values immediately. Any late response after reset is ignored, because state=IDLE does not accept responses.

Decomposition:
- core_pkg:
  - fetch_state_e enum.
  - fetch_entry_t struct {word_t instr; word_t pc; logic fault;}.
  - Uses existing word_t.
- Sub-module core_fetch_queue: generic DEPTH-entry FIFO of fetch_entry_t with synchronous flush, count output, push/pop.
- core_fetch_unit holds the FSM, fetch_pc and credit logic.

Test Plan:
1. Reset release, imem_req_ready=1, memory returns 1 cycle after accept; decode always ready -> imem_req_addr sequence 0x0,0x4,0x8. instr_pc matches each address; instr_valid follows each response by 1 cycle.
2. DEPTH=4, instr_ready=0 -> exactly 4 requests issued, then imem_req_valid stays 0. After one dequeue, exactly one more request.
3. imem_req_ready=0 for 3 cycles, redirect_pc=0x100 in cycle 2 -> addr stays 0x0 until accept, then that response is discarded. Next request addr=0x100; queue empty before it.
4. Redirect in the same cycle as a WAIT response -> response not enqueued, instr_valid=0 next cycle. Next request addr=redirect target.
5. Response with imem_rsp_fault=1 at pc 0x8 -> entry pc=0x8 with instr_fault=1; no further requests until redirect to 0x200 restarts fetch there.
6. RESET_PC=32'hFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Also: rst_n low during WAIT -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the LETC core front-end: machine word, fetch FSM states
// and the fetch queue entry.
package core_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT      = 3'd2,
        KILL_REQ  = 3'd3,
        KILL_WAIT = 3'd4,
        FAULT     = 3'd5
    } fetch_state_e;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  fault;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic word_t pc_next(input word_t pc);
        return pc + word_t'(4);
    endfunction

endpackage

// File: rtl/core_fetch_queue.sv
// DEPTH-entry FIFO of fetch entries with synchronous flush; head is read
// straight from storage so a pushed entry becomes visible one cycle later.
module core_fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head_entry,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        push_ok  = push && (count_q < CW'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/core_fetch_unit.sv
// Instruction fetch front-end: sequential address generation with a single
// outstanding request, credit-limited queueing and redirect/kill handling.
module core_fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter word_t       RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_fault,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = CW + 1;

    fetch_state_e  state_q, state_d;
    word_t         fetch_pc_q, fetch_pc_d;
    word_t         req_addr_q, req_addr_d;
    logic          req_valid_q, req_valid_d;

    fetch_entry_t  head_entry;
    fetch_entry_t  push_entry;
    logic          head_valid;
    logic [CW-1:0] q_count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          outstanding;
    logic          credit;

    core_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .head_valid (head_valid),
        .count      (q_count)
    );

    // Queue handshakes and credit; a redirect empties the queue next cycle.
    always_comb begin
        instr_valid = head_valid && !redirect_valid;
        pop         = instr_valid && instr_ready;
        push        = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
        push_entry  = '{instr: imem_rsp_data, pc: req_addr_q, fault: imem_rsp_fault};
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = q_count + CW'(push) - CW'(pop);
        end
        outstanding = ((state_q == WAIT) || (state_q == KILL_WAIT)) && !imem_rsp_valid;
        credit      = ({1'b0, count_next} + {{CW{1'b0}}, outstanding}) < CNT_W'(DEPTH);
    end

    // Next-state, fetch PC and request register logic.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                if (credit) state_d = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    fetch_pc_d = pc_next(fetch_pc_q);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_fault) state_d = FAULT;
                    else                state_d = credit ? REQ : IDLE;
                end
            end
            KILL_REQ: begin
                if (imem_req_ready) state_d = KILL_WAIT;
            end
            KILL_WAIT: begin
                if (imem_rsp_valid) state_d = credit ? REQ : IDLE;
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~word_t'(3);
            unique case (state_q)
                IDLE, FAULT: state_d = IDLE;
                REQ:         state_d = imem_req_ready ? KILL_WAIT : KILL_REQ;
                WAIT:        state_d = imem_rsp_valid ? IDLE : KILL_WAIT;
                // Kill states keep draining the stale transaction.
                default:     state_d = state_d;
            endcase
        end

        req_valid_d = (state_d == REQ) || (state_d == KILL_REQ);
        req_addr_d  = req_addr_q;
        if ((state_d == REQ) && (state_q != REQ)) begin
            req_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign instr          = head_entry.instr;
    assign instr_pc       = head_entry.pc;
    assign instr_fault    = head_entry.fault;

endmodule
